// File: rtl/uart_transmitter_if.sv
// Byte push port between the local producer and the UART transmitter.
interface uart_transmitter_if;
    logic [7:0] data;
    logic       send;
    logic       ready;

    modport master (output data, output send, input ready);
    modport slave  (input data, input send, output ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered bytes serialised as start, 8 data LSB-first,
// optional even parity (UART_TX_PARITY_EN), stop; one bit per clk cycle.
module uart_transmitter #(
    parameter int DEPTH    = 4,
    parameter int IDLE_GAP = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_transmitter_if.slave        bus,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    head;
    logic [2:0]    state;
    logic [7:0]    shift;
    logic [2:0]    idx;
    logic [3:0]    gap_cnt;
    logic          push, pop, gap_last;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign head      = mem[rd_ptr];
    assign bus.ready = (level != LW'(DEPTH));
    assign push      = bus.send && bus.ready;
    assign gap_last  = (gap_cnt == 4'(IDLE_GAP - 1));
    assign busy      = (state != S_IDLE) || (level != '0);

    // Pop points: IDLE, STOP when frames run back-to-back, and the last GAP
    // cycle so that exactly IDLE_GAP idle bits separate consecutive frames.
    always_comb begin
        pop = 1'b0;
        if (level != '0) begin
            case (state)
                S_IDLE:  pop = 1'b1;
                S_STOP:  pop = (IDLE_GAP == 0);
                S_GAP:   pop = gap_last;
                default: pop = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= bus.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // tx is registered with the bit of the state being entered, so the start
    // bit appears on the edge right after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            idx     <= '0;
            gap_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: tx <= 1'b1;
                S_START: begin
                    tx    <= shift[0];
                    shift <= shift >> 1;
                    idx   <= '0;
                    state <= S_DATA;
                end
                S_DATA: begin
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx    <= par;
                        state <= S_PARITY;
`else
                        tx    <= 1'b1;
                        state <= S_STOP;
`endif
                    end else begin
                        tx    <= shift[0];
                        shift <= shift >> 1;
                        idx   <= idx + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx    <= 1'b1;
                    state <= S_STOP;
                end
`endif
                S_STOP: begin
                    tx      <= 1'b1;
                    gap_cnt <= '0;
                    state   <= (IDLE_GAP > 0) ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    tx      <= 1'b1;
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_last) state <= S_IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
            // A pop overrides whatever the state case chose.
            if (pop) begin
                shift <= head;
`ifdef UART_TX_PARITY_EN
                par   <= ^head;
`endif
                tx    <= 1'b0;
                state <= S_START;
            end
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default instance plus an IDLE_GAP=2 one.
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx0, busy0, tx1, busy1;
    logic [2:0] level0, level1;
    int         checks = 0;
    int         failures = 0;

    uart_transmitter_if b0();
    uart_transmitter_if b1();

    uart_transmitter #(.DEPTH(4), .IDLE_GAP(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0), .tx(tx0), .busy(busy0), .level(level0));
    uart_transmitter #(.DEPTH(4), .IDLE_GAP(2)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .tx(tx1), .busy(busy1), .level(level1));

    always #5 clk = ~clk;

    // Bit i of the serial frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset();
        b0.send = 1'b0; b0.data = 8'h00;
        b1.send = 1'b0; b1.data = 8'h00;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== 1'b1 || b0.ready !== 1'b1 || busy0 !== 1'b0 || level0 !== 3'd0) begin
                failures++;
                $display("FAIL reset_idle c=%0d tx=%b ready=%b busy=%b level=%0d want 1 1 0 0",
                         c, tx0, b0.ready, busy0, level0);
            end
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        @(negedge clk);
        b0.data = b; b0.send = 1'b1;
        @(negedge clk);
        b0.send = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== frame_bit(b, i)) begin
                failures++;
                $display("FAIL single_%h bit%0d tx=%b want %b", b, i, tx0, frame_bit(b, i));
            end
        end
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL single_%h busy_in_stop busy=%b want 1", b, busy0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
            failures++;
            $display("FAIL single_%h after_stop busy=%b tx=%b want 0 1", b, busy0, tx0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic   q[$];
        logic   will;
        int     acc;
        logic [7:0] exp_b;
        @(negedge clk);
        b0.send = 1'b1; b0.data = 8'h11; acc = 0;
        for (int c = 0; c < 5*FL + 4; c++) begin
            will = b0.send && b0.ready;
            @(negedge clk);
            if (will) begin acc++; b0.data = 8'(8'h11 + acc); end
            q.push_back(tx0);
            if (c == 3) begin
                checks++;
                if (b0.ready !== 1'b1 || level0 !== 3'd3) begin
                    failures++;
                    $display("FAIL fill_level3 ready=%b level=%0d want 1 3", b0.ready, level0);
                end
            end
            if (c == 7) begin
                checks++;
                if (b0.ready !== 1'b0 || level0 !== 3'd4 || acc != 5) begin
                    failures++;
                    $display("FAIL fill_full ready=%b level=%0d acc=%0d want 0 4 5", b0.ready, level0, acc);
                end
                b0.send = 1'b0;
            end
        end
        checks++;
        if (q[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pre tx=%b want 1", q[0]);
        end
        for (int f = 0; f < 5; f++) begin
            exp_b = 8'(8'h11 + f);
            for (int i = 0; i < FL; i++) begin
                checks++;
                if (q[1 + f*FL + i] !== frame_bit(exp_b, i)) begin
                    failures++;
                    $display("FAIL b2b_frame%0d bit%0d tx=%b want %b", f, i, q[1 + f*FL + i], frame_bit(exp_b, i));
                end
            end
        end
        for (int k = 5*FL + 1; k < 5*FL + 4; k++) begin
            checks++;
            if (q[k] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_tail idx=%0d tx=%b want 1", k, q[k]);
            end
        end
        checks++;
        if (busy0 !== 1'b0 || acc != 5 || level0 !== 3'd0) begin
            failures++;
            $display("FAIL b2b_end busy=%b acc=%0d level=%0d want 0 5 0", busy0, acc, level0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gap();
        logic q[$];
        logic exp;
        @(negedge clk);
        b1.send = 1'b1; b1.data = 8'h11;
        @(negedge clk);
        q.push_back(tx1);
        b1.data = 8'h12;
        @(negedge clk);
        q.push_back(tx1);
        b1.send = 1'b0;
        for (int c = 2; c < 2*FL + 6; c++) begin
            @(negedge clk);
            q.push_back(tx1);
        end
        // q[1..FL] frame 0x11, two gap bits, q[FL+3..2FL+2] frame 0x12.
        for (int k = 1; k < 2*FL + 6; k++) begin
            if (k <= FL)               exp = frame_bit(8'h11, k - 1);
            else if (k <= FL + 2)      exp = 1'b1;
            else if (k <= 2*FL + 2)    exp = frame_bit(8'h12, k - FL - 3);
            else                       exp = 1'b1;
            checks++;
            if (q[k] !== exp) begin
                failures++;
                $display("FAIL gap idx=%0d tx=%b want %b", k, q[k], exp);
            end
        end
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL gap_end busy=%b want 0", busy1);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        b0.send = 1'b1; b0.data = 8'hFF;
        @(negedge clk);
        b0.data = 8'h00;
        @(negedge clk);
        b0.send = 1'b0;
        // Now after the start-bit edge; step to data bit 3.
        repeat (4) @(negedge clk);
        checks++;
        if (tx0 !== 1'b1 || level0 !== 3'd1 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_before tx=%b level=%0d busy=%b want 1 1 1", tx0, level0, busy0);
        end
        reset = 1'b1;
        b0.send = 1'b1; b0.data = 8'h42;
        @(negedge clk);
        reset = 1'b0;
        b0.send = 1'b0;
        checks++;
        if (tx0 !== 1'b1 || level0 !== 3'd0 || b0.ready !== 1'b1 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset tx=%b level=%0d ready=%b busy=%b want 1 0 1 0",
                     tx0, level0, b0.ready, busy0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL mid_after c=%0d tx=%b busy=%b want 1 0", c, tx0, busy0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'h01);
        test_back_to_back();
        test_gap();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmitter for the project's UART link: accepts bytes from the local logic through a valid/ready push port, buffers them in a small FIFO, and serialises each one onto `tx` at one bit per `clk` cycle. It is the sending end of the same frame format the receiver decodes: start bit 0, 8 data bits LSB first, even parity, and stop bit 1. It sits between the command/data logic and the board TX pin.

## Interface
- `DEPTH`, default 4: number of FIFO entries; a power of two ≥ 2.
- `IDLE_GAP`, default 0: extra idle (`tx`=1) cycles inserted after each stop bit before the next start bit; range 0–15.
- `clk` in 1: single clock; one serial bit per cycle. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `data` in 8: byte to send; sampled on a push.
- `send` in 1: push request.
- `ready` out 1: `level != DEPTH`. Combinational from the registered level.
- `tx` out 1: registered serial line; idles at 1.
- `busy` out 1: high when the FSM is not IDLE or `level != 0`.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: at a rising edge with `send && ready`, `data` is written at the tail. If `send` is high while `ready` is low, `data` is ignored and nothing is flagged.
- FSM states:
  - IDLE: `tx`=1. If `level != 0`, pop the head into the shift register and go to START.
  - START: `tx`=0 for one cycle, then go to DATA.
  - DATA: `tx` = shift[0]. Shift right; a 3-bit index runs 0..7. After bit 7, go to PARITY.
  - PARITY: `tx` = ^byte (XOR of the 8 data bits, even parity), then go to STOP.
  - STOP: `tx`=1 for one cycle.
    - If `IDLE_GAP`=0 and `level != 0`, pop and go to START, giving back-to-back frames.
    - Otherwise, if `IDLE_GAP`>0, go to GAP.
    - Otherwise, go to IDLE.
  - GAP: `tx`=1 for `IDLE_GAP` cycles, counted by a 4-bit counter, then go to IDLE.
- Frame length is 11 cycles with parity; `IDLE_GAP` cycles are added between frames.
- Simultaneous push and pop in the same cycle: `level` stays unchanged; the FIFO pointers wrap modulo DEPTH.
- A pop only occurs when `level != 0`; an empty FIFO never underflows.
- The byte being transmitted lives in the shift register and no longer occupies a FIFO slot.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0, `level`=0, FSM=IDLE, pointers=0.
- Latency, FIFO empty and FSM in IDLE: a push at edge N makes `tx`=0 (start bit) valid from edge N+1. The first data bit appears from edge N+2.
- `ready` drops in the cycle after the edge that makes `level` equal DEPTH. It rises in the cycle after the next pop.
- Reset asserted mid-frame: at that edge `tx` returns to 1, the FIFO is flushed, and the FSM goes to IDLE. The partial frame is truncated; the receiver will reject it on parity or stop.
- `send` is ignored during any cycle where `reset`=1.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is present and the frame is 11 bits (start, 8 data, even parity, stop). This matches the receiver.
  - Undefined: the PARITY state is removed, DATA goes directly to STOP, and the frame is 10 bits. The parity logic is not synthesised.

## Test plan
- Reset, then idle for 20 cycles → `tx`=1, `ready`=1, `busy`=0, `level`=0 throughout.
- Push 0xA5 once → `tx` from the next cycle reads 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity 0, stop). `busy` falls one cycle after the stop bit.
- Push 0x01 → data bits 1,0,0,0,0,0,0,0, parity bit 1. Build without `UART_TX_PARITY_EN` → 10-bit frame with no parity bit.
- With DEPTH=4, hold `send`=1 with bytes 0x11,0x12,… → exactly 5 bytes (0x11–0x15) are accepted, then `ready`=0. The 5 frames go out back-to-back in order, 55 cycles total, with no idle bits between them.
- Set `IDLE_GAP`=2 and push 0x11,0x12 → exactly 2 extra cycles of `tx`=1 between the first stop bit and the second start bit.
- Push 0xFF, 0x00, then assert `reset` during data bit 3 of the first frame → `tx`=1 from the next cycle, `level`=0, `ready`=1, and 0x00 is never transmitted.
